// File: rtl/fpu_pkg.sv
// Shared FPU encodings: operation codes, OP-FP opcode, funct7 and fixed rs2
// selectors. The control decoder imports the same package, so encoder and
// decoder always agree on the instruction layout.
package fpu_pkg;

    typedef enum logic [2:0] {
        FPU_ADD     = 3'b000,
        FPU_SUB     = 3'b001,
        FPU_MUL     = 3'b010,
        FPU_DIV     = 3'b011,
        FPU_SQRT    = 3'b100,
        FPU_FCVT_LD = 3'b101,
        FPU_FCVT_DL = 3'b110,
        FPU_INVALID = 3'b111
    } fpu_op_e;

    localparam logic [6:0] OP_FP        = 7'b1010011;

    localparam logic [6:0] F7_FADD_D    = 7'b0000001;
    localparam logic [6:0] F7_FSUB_D    = 7'b0000101;
    localparam logic [6:0] F7_FMUL_D    = 7'b0001001;
    localparam logic [6:0] F7_FDIV_D    = 7'b0001101;
    localparam logic [6:0] F7_FSQRT_D   = 7'b0101101;
    localparam logic [6:0] F7_FCVT_L_D  = 7'b1100001;
    localparam logic [6:0] F7_FCVT_D_L  = 7'b1101001;

    // rs2 field is an operation selector for the unary ops, not a register
    localparam logic [4:0] RS2_FCVT_SEL = 5'b00010;
    localparam logic [4:0] RS2_SQRT_SEL = 5'b00000;

    // Assemble an R-type OP-FP word from its fields
    function automatic logic [31:0] pack_op_fp(
        input logic [6:0] funct7,
        input logic [4:0] rs2,
        input logic [4:0] rs1,
        input logic [2:0] rm,
        input logic [4:0] rd
    );
        return {funct7, rs2, rs1, rm, rd, OP_FP};
    endfunction

endpackage

// File: rtl/fpu_instr_fifo.sv
// DEPTH x 32 synchronous FIFO. Occupancy is kept in its own counter so full
// and empty are unambiguous while the pointers wrap modulo DEPTH.
module fpu_instr_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [31:0]            push_data,
    input  logic                   pop,
    output logic [31:0]            pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign pop_data  = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage array: write at the tail on an accepted push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers advance independently and wrap naturally (DEPTH is a power of two)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Occupancy: unchanged on simultaneous push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fpu_instr_encoder.sv
// FPU instruction encoder: turns an fpu_op plus register indices into an
// RV64D OP-FP word and queues it for the fetch side. Invalid ops complete
// the handshake but are dropped and flagged on err the following cycle.
module fpu_instr_encoder
    import fpu_pkg::*;
#(
    parameter int         DEPTH = 4,
    parameter logic [2:0] RM    = 3'b111
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_op,
    input  logic [4:0]             in_rd,
    input  logic [4:0]             in_rs1,
    input  logic [4:0]             in_rs2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err
);

    logic        full_s;
    logic        empty_s;
    logic        accept_s;
    logic        invalid_s;
    logic        push_s;
    logic        pop_s;
    logic [31:0] word_s;
    logic        err_r;

    // Unary ops carry a fixed selector in rs2; the caller's rs2 is ignored
    function automatic logic [31:0] encode_word(
        input logic [2:0] op,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        logic [6:0] f7;
        logic [4:0] r2;
        f7 = 7'b0000000;
        r2 = rs2;
        case (fpu_op_e'(op))
            FPU_ADD:     f7 = F7_FADD_D;
            FPU_SUB:     f7 = F7_FSUB_D;
            FPU_MUL:     f7 = F7_FMUL_D;
            FPU_DIV:     f7 = F7_FDIV_D;
            FPU_SQRT: begin
                f7 = F7_FSQRT_D;
                r2 = RS2_SQRT_SEL;
            end
            FPU_FCVT_LD: begin
                f7 = F7_FCVT_L_D;
                r2 = RS2_FCVT_SEL;
            end
            FPU_FCVT_DL: begin
                f7 = F7_FCVT_D_L;
                r2 = RS2_FCVT_SEL;
            end
            default: begin
                f7 = 7'b0000000;
                r2 = 5'b00000;
            end
        endcase
        return pack_op_fp(f7, r2, rs1, RM, rd);
    endfunction

    // Handshake qualification and invalid-op filter
    always_comb begin
        word_s    = encode_word(in_op, in_rd, in_rs1, in_rs2);
        accept_s  = in_valid && !full_s;
        invalid_s = (in_op == 3'(FPU_INVALID));
        if (accept_s && !invalid_s) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        pop_s = !empty_s && out_ready;
    end

    fpu_instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (word_s),
        .pop       (pop_s),
        .pop_data  (out_instr),
        .count     (count),
        .full      (full_s),
        .empty     (empty_s)
    );

    // One-cycle error pulse for every accepted invalid op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= accept_s && invalid_s;
        end
    end

    assign in_ready  = !full_s;
    assign out_valid = !empty_s;
    assign err       = err_r;

endmodule
